// File: rtl/bg_pic_writer.sv
// bg_pic_writer: background-picture download writer.
// Packs HPS ioctl bytes into 16-bit words, buffers them in a small FIFO and
// writes them to SDRAM over a req/ack handshake. Raises use_bg once a complete
// image is resident. Optional feature macro: BG_CHECKSUM_EN (running 16-bit
// sum of written words on the checksum port).
module bg_pic_writer #(
  parameter int unsigned ADDR_W    = 25,
  parameter logic [7:0]  INDEX     = 8'd2,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned IMG_BYTES = 614400
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  input  logic              sdram_present,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  input  logic              mem_ack,
  output logic              use_bg,
  output logic [ADDR_W-1:0] byte_cnt,
  output logic [15:0]       checksum
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] IMG_LIM = ADDR_W'(IMG_BYTES);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } word_t;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t            state;
  word_t             fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_next;

  logic              sel;
  logic              sel_q;
  logic              sel_rise;
  logic              sel_fall;
  logic              accept;
  logic              half;
  logic              half_eff;
  logic [7:0]        lo;
  logic [ADDR_W-1:0] wa;
  logic              overflow;
  logic              pending;
  logic              done;

  logic              push;
  word_t             push_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic              do_push;
  logic              pop;

  assign sel        = ioctl_download & (ioctl_index == INDEX);
  assign sel_rise   = sel & ~sel_q;
  assign sel_fall   = ~sel & sel_q;
  assign accept     = sel & ioctl_wr;
  assign half_eff   = half & ~sel_rise;
  assign fifo_full  = (fifo_count == CNT_W'(DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign pop        = (state == S_REQ) & mem_ack;
  assign do_push    = push & ~fifo_full;
  assign count_next = fifo_count + CNT_W'(do_push) - CNT_W'(pop);
  assign done       = pending & ~sel & ~sel_q & fifo_empty & (state == S_IDLE);

  // Word assembly: odd byte completes a pair, falling sel flushes a lone even byte
  always_comb begin
    push      = 1'b0;
    push_word = '0;
    if (accept && ioctl_addr[0]) begin
      push           = 1'b1;
      push_word.addr = half_eff ? wa : {ioctl_addr[ADDR_W-1:1], 1'b0};
      push_word.data = {ioctl_dout, (half_eff ? lo : 8'h00)};
    end else if (sel_fall && half) begin
      push           = 1'b1;
      push_word.addr = wa;
      push_word.data = {8'h00, lo};
    end
  end

  // Download tracking: half-word latch, byte count, overflow and completion
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sel_q    <= 1'b0;
      half     <= 1'b0;
      lo       <= '0;
      wa       <= '0;
      byte_cnt <= '0;
      overflow <= 1'b0;
      pending  <= 1'b0;
      use_bg   <= 1'b0;
    end else begin
      sel_q    <= sel;
      byte_cnt <= (sel_rise ? '0 : byte_cnt) + ADDR_W'(accept);
      overflow <= (sel_rise ? 1'b0 : overflow) | (push & fifo_full);
      if (accept) begin
        if (!ioctl_addr[0]) begin
          lo   <= ioctl_dout;
          wa   <= ioctl_addr;
          half <= 1'b1;
        end else begin
          half <= 1'b0;
        end
      end else if (sel_rise || sel_fall) begin
        half <= 1'b0;
      end
      if (sel_rise) begin
        pending <= 1'b1;
        use_bg  <= 1'b0;
      end else if (done) begin
        pending <= 1'b0;
        use_bg  <= sdram_present & ~overflow & (byte_cnt >= IMG_LIM);
      end
    end
  end

  // FIFO storage; a push on a full FIFO is dropped
  always_ff @(posedge clk_sys) begin
    if (do_push) begin
      fifo_mem[wr_ptr] <= push_word;
    end
  end

  // FIFO pointers, occupancy and stall request to the HPS
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ioctl_wait <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= count_next;
      ioctl_wait <= (count_next >= CNT_W'(DEPTH - 1));
    end
  end

  // SDRAM write FSM: load head word, hold request until acknowledged
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= S_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            mem_addr <= fifo_mem[rd_ptr].addr;
            mem_din  <= fifo_mem[rd_ptr].data;
            mem_req  <= 1'b1;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BG_CHECKSUM_EN
  // Running sum of every word the controller has acknowledged
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      checksum <= '0;
    end else begin
      checksum <= (sel_rise ? 16'h0000 : checksum) + (pop ? mem_din : 16'h0000);
    end
  end
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_bg_pic_writer.sv
// tb_bg_pic_writer: directed self-checking bench for bg_pic_writer.
// Runs with a reduced image size so complete downloads stay short.
module tb_bg_pic_writer;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned IMG    = 8;

  logic              clk;
  logic              reset;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic              sdram_present;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;
  logic              mem_ack;
  logic              use_bg;
  logic [ADDR_W-1:0] byte_cnt;
  logic [15:0]       checksum;

  logic              auto_ack;
  logic              auto_pulse;
  logic              man_ack;
  int                ack_lat;
  logic [ADDR_W-1:0] wq_a[$];
  logic [15:0]       wq_d[$];
  int                wr_base;
  int                total;
  int                bad;

  assign mem_ack = auto_pulse | man_ack;

  bg_pic_writer #(
    .ADDR_W(ADDR_W), .INDEX(8'd2), .DEPTH(DEPTH), .IMG_BYTES(IMG)
  ) dut (
    .clk_sys(clk), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .sdram_present(sdram_present),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ack(mem_ack), .use_bg(use_bg), .byte_cnt(byte_cnt),
    .checksum(checksum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SDRAM controller model: acks after ack_lat request cycles and logs writes
  initial begin
    int lat_cnt;
    lat_cnt    = 0;
    auto_pulse = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      auto_pulse = 1'b0;
      if (auto_ack && mem_req && !reset) begin
        lat_cnt++;
        if (lat_cnt >= ack_lat) begin
          auto_pulse = 1'b1;
          wq_a.push_back(mem_addr);
          wq_d.push_back(mem_din);
          lat_cnt = 0;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic send_hw(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    for (int i = 0; i < 100 && ioctl_wait; i++) tick();
    if (ioctl_wait) begin
      total++; bad++;
      $display("FAIL wait_stuck: ioctl_wait=%b required 0 within 100 cycles", ioctl_wait);
    end
    send_byte(a, d);
  endtask

  task automatic start_dl();
    ioctl_index    = 8'd2;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic run_dl(input logic [ADDR_W-1:0] base, input int n, input logic [7:0] d0);
    start_dl();
    for (int i = 0; i < n; i++) send_hw(base + ADDR_W'(i), 8'(d0 + 8'(i)));
    end_dl();
  endtask

  task automatic wait_writes(input int n, output bit ok);
    for (int i = 0; i < 400; i++) begin
      if (wq_a.size() >= wr_base + n) break;
      tick();
    end
    ok = (wq_a.size() >= wr_base + n);
    tick(3);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", mem_req); end
    if (mem_addr !== '0) begin bad++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
    if (mem_din !== 16'h0) begin bad++; $display("FAIL rst_din: got %h want 0", mem_din); end
    if (use_bg !== 1'b0) begin bad++; $display("FAIL rst_use_bg: got %b want 0", use_bg); end
    if (byte_cnt !== '0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", byte_cnt); end
    if (checksum !== 16'h0) begin bad++; $display("FAIL rst_sum: got %h want 0", checksum); end
    if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL rst_wait: got %b want 0", ioctl_wait); end
    total += 7;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_word();
    bit got;
    auto_ack = 1'b0;
    start_dl();
    send_byte(25'd0, 8'h11);
    send_byte(25'd1, 8'h22);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) begin got = 1'b1; break; end
      tick();
    end
    total += 3;
    if (!got) begin bad++; $display("FAIL w1_req: mem_req=%b want 1", mem_req); end
    if (mem_addr !== 25'd0) begin bad++; $display("FAIL w1_addr: got %h want 0", mem_addr); end
    if (mem_din !== 16'h2211) begin bad++; $display("FAIL w1_din: got %h want 2211", mem_din); end
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (mem_req !== 1'b1) begin bad++; $display("FAIL w1_hold%0d: got %b want 1", k, mem_req); end
    end
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    total++;
    if (mem_req !== 1'b0) begin bad++; $display("FAIL w1_drop: got %b want 0", mem_req); end
    end_dl();
    tick(4);
    total += 3;
    if (byte_cnt !== 25'd2) begin bad++; $display("FAIL w1_cnt: got %0d want 2", byte_cnt); end
    if (use_bg !== 1'b0) begin bad++; $display("FAIL w1_use_bg: got %b want 0", use_bg); end
`ifdef BG_CHECKSUM_EN
    if (checksum !== 16'h2211) begin bad++; $display("FAIL w1_sum: got %h want 2211", checksum); end
`else
    if (checksum !== 16'h0000) begin bad++; $display("FAIL w1_sum: got %h want 0", checksum); end
`endif
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [15:0] exp_d [4];
    exp_d[0] = 16'h3130; exp_d[1] = 16'h3332; exp_d[2] = 16'h3534; exp_d[3] = 16'h3736;
    auto_ack = 1'b0;
    wr_base  = wq_a.size();
    start_dl();
    for (int i = 0; i < 8; i++) begin
      send_byte(ADDR_W'(i), 8'(8'h30 + 8'(i)));
      if (i == 3) begin
        total++;
        if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL bp_wait2: got %b want 0", ioctl_wait); end
      end
      if (i == 5 || i == 7) begin
        total++;
        if (ioctl_wait !== 1'b1) begin bad++; $display("FAIL bp_wait_at%0d: got %b want 1", i, ioctl_wait); end
      end
    end
    end_dl();
    tick(5);
    total += 2;
    if (use_bg !== 1'b0) begin bad++; $display("FAIL bp_early_done: use_bg=%b want 0", use_bg); end
    if (mem_req !== 1'b1) begin bad++; $display("FAIL bp_req_held: got %b want 1", mem_req); end
    ack_lat  = 1;
    auto_ack = 1'b1;
    wait_writes(4, ok);
    total++;
    if (!ok || wq_a.size() - wr_base != 4) begin
      bad++; $display("FAIL bp_nwrites: got %0d want 4", wq_a.size() - wr_base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wq_a[wr_base+i] !== ADDR_W'(2*i) || wq_d[wr_base+i] !== exp_d[i]) begin
          bad++;
          $display("FAIL bp_word%0d: got %h/%h want %h/%h", i, wq_a[wr_base+i], wq_d[wr_base+i], 2*i, exp_d[i]);
        end
      end
    end
    total += 3;
    if (use_bg !== 1'b1) begin bad++; $display("FAIL bp_use_bg: got %b want 1", use_bg); end
    if (byte_cnt !== 25'd8) begin bad++; $display("FAIL bp_cnt: got %0d want 8", byte_cnt); end
    if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL bp_wait_end: got %b want 0", ioctl_wait); end
  endtask

  task automatic test_overflow();
    bit ok;
    auto_ack = 1'b0;
    wr_base  = wq_a.size();
    start_dl();
    for (int i = 0; i < 10; i++) send_byte(ADDR_W'(i), 8'(i));
    end_dl();
    ack_lat  = 1;
    auto_ack = 1'b1;
    wait_writes(4, ok);
    tick(5);
    total += 4;
    if (!ok || wq_a.size() - wr_base != 4) begin
      bad++; $display("FAIL ov_nwrites: got %0d want 4", wq_a.size() - wr_base);
    end
    if (wq_a[wq_a.size()-1] !== 25'd6) begin bad++; $display("FAIL ov_last_addr: got %h want 6", wq_a[wq_a.size()-1]); end
    if (use_bg !== 1'b0) begin bad++; $display("FAIL ov_use_bg: got %b want 0", use_bg); end
    if (byte_cnt !== 25'd10) begin bad++; $display("FAIL ov_cnt: got %0d want 10", byte_cnt); end
  endtask

  task automatic test_odd_tail();
    bit ok;
    ack_lat  = 2;
    auto_ack = 1'b1;
    wr_base  = wq_a.size();
    run_dl(25'd0, 3, 8'hA0);
    wait_writes(2, ok);
    total += 4;
    if (!ok || wq_a.size() - wr_base != 2) begin
      bad++; $display("FAIL odd_nwrites: got %0d want 2", wq_a.size() - wr_base);
    end
    if (wq_a[wq_a.size()-1] !== 25'd2 || wq_d[wq_d.size()-1] !== 16'h00A2) begin
      bad++; $display("FAIL odd_flush: got %h/%h want 2/00a2", wq_a[wq_a.size()-1], wq_d[wq_d.size()-1]);
    end
    if (byte_cnt !== 25'd3) begin bad++; $display("FAIL odd_cnt: got %0d want 3", byte_cnt); end
    if (use_bg !== 1'b0) begin bad++; $display("FAIL odd_use_bg: got %b want 0", use_bg); end
    // Lone odd byte: low half zero, word address rounded down
    wr_base = wq_a.size();
    run_dl(25'd5, 1, 8'hAB);
    wait_writes(1, ok);
    total++;
    if (!ok || wq_a[wq_a.size()-1] !== 25'd4 || wq_d[wq_d.size()-1] !== 16'hAB00) begin
      bad++; $display("FAIL lone_odd: got %h/%h want 4/ab00", wq_a[wq_a.size()-1], wq_d[wq_d.size()-1]);
    end
    // Strobes for another index are ignored
    wr_base        = wq_a.size();
    ioctl_index    = 8'd3;
    ioctl_download = 1'b1;
    tick();
    send_byte(25'd0, 8'h77);
    send_byte(25'd1, 8'h88);
    tick(6);
    ioctl_download = 1'b0;
    tick();
    total += 2;
    if (wq_a.size() != wr_base) begin bad++; $display("FAIL unsel_write: got %0d writes want 0", wq_a.size() - wr_base); end
    if (byte_cnt !== 25'd1) begin bad++; $display("FAIL unsel_cnt: got %0d want 1", byte_cnt); end
  endtask

  task automatic test_image();
    bit ok;
    ack_lat  = 1;
    auto_ack = 1'b1;
    sdram_present = 1'b1;
    wr_base = wq_a.size();
    run_dl(25'd0, 8, 8'h40);
    wait_writes(4, ok);
    total += 2;
    if (!ok) begin bad++; $display("FAIL img_writes: got %0d want 4", wq_a.size() - wr_base); end
    if (use_bg !== 1'b1) begin bad++; $display("FAIL img_use_bg: got %b want 1", use_bg); end
    start_dl();
    total++;
    if (use_bg !== 1'b0) begin bad++; $display("FAIL img_rise_clear: got %b want 0", use_bg); end
    end_dl();
    tick(3);
    sdram_present = 1'b0;
    wr_base = wq_a.size();
    run_dl(25'd0, 8, 8'h50);
    wait_writes(4, ok);
    total++;
    if (use_bg !== 1'b0) begin bad++; $display("FAIL img_no_sdram: got %b want 0", use_bg); end
    sdram_present = 1'b1;
    wr_base = wq_a.size();
    run_dl(25'd0, IMG - 1, 8'h60);
    wait_writes(4, ok);
    total++;
    if (use_bg !== 1'b0) begin bad++; $display("FAIL img_short: got %b want 0 (cnt %0d)", use_bg, byte_cnt); end
    wr_base = wq_a.size();
    run_dl(25'd0, 8, 8'h70);
    wait_writes(4, ok);
    total++;
    if (use_bg !== 1'b1) begin bad++; $display("FAIL img_again: got %b want 1", use_bg); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit req_seen;
    auto_ack = 1'b0;
    start_dl();
    for (int i = 0; i < 4; i++) send_byte(25'h20 + ADDR_W'(i), 8'(8'hC0 + 8'(i)));
    tick(2);
    req_seen = mem_req;
    total++;
    if (req_seen !== 1'b1) begin bad++; $display("FAIL rm_req_pre: got %b want 1", req_seen); end
    reset          = 1'b1;
    ioctl_download = 1'b0;
    tick();
    total += 5;
    if (mem_req !== 1'b0) begin bad++; $display("FAIL rm_req: got %b want 0", mem_req); end
    if (mem_addr !== '0) begin bad++; $display("FAIL rm_addr: got %h want 0", mem_addr); end
    if (use_bg !== 1'b0) begin bad++; $display("FAIL rm_use_bg: got %b want 0", use_bg); end
    if (byte_cnt !== '0) begin bad++; $display("FAIL rm_cnt: got %0d want 0", byte_cnt); end
    if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL rm_wait: got %b want 0", ioctl_wait); end
    reset   = 1'b0;
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (mem_req !== 1'b0 || ioctl_wait !== 1'b0) begin
        bad++; $display("FAIL rm_idle%0d: req=%b wait=%b want 0/0", k, mem_req, ioctl_wait);
      end
    end
    ack_lat  = 1;
    auto_ack = 1'b1;
    wr_base  = wq_a.size();
    run_dl(25'h10, 2, 8'h5A);
    wait_writes(1, ok);
    total++;
    if (!ok || wq_a.size() - wr_base != 1 || wq_a[wr_base] !== 25'h10 || wq_d[wr_base] !== 16'h5B5A) begin
      bad++; $display("FAIL rm_after: writes=%0d got %h/%h want 1 write 10/5b5a",
                      wq_a.size() - wr_base, mem_addr, mem_din);
    end
  endtask

  task automatic test_checksum();
    bit ok;
    ack_lat  = 1;
    auto_ack = 1'b1;
    wr_base  = wq_a.size();
    start_dl();
    send_hw(25'd0, 8'hFF);
    send_hw(25'd1, 8'hFF);
    send_hw(25'd2, 8'h02);
    send_hw(25'd3, 8'h00);
    end_dl();
    wait_writes(2, ok);
    total += 2;
    if (!ok) begin bad++; $display("FAIL cs_writes: got %0d want 2", wq_a.size() - wr_base); end
`ifdef BG_CHECKSUM_EN
    if (checksum !== 16'h0001) begin bad++; $display("FAIL cs_value: got %h want 0001", checksum); end
`else
    if (checksum !== 16'h0000) begin bad++; $display("FAIL cs_value: got %h want 0000", checksum); end
`endif
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    wr_base        = 0;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = 8'h00;
    sdram_present  = 1'b1;
    auto_ack       = 1'b0;
    man_ack        = 1'b0;
    ack_lat        = 1;
    test_reset();
    test_single_word();
    test_backpressure();
    test_overflow();
    test_odd_tail();
    test_image();
    test_reset_mid();
    test_checksum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
